jtag_soc_mailbox: RTL and testbench
===================================

Name: jtag_soc_mailbox

Overview:
- SoC-side consumer of the 8-bit JTAG configuration byte that the TAP wrapper exports as soc_jtag_reg_o.
- Turns that static register into a flow-controlled host-to-SoC byte channel with a small RX FIFO.
- Drives the byte returned to the TAP wrapper's soc_jtag_reg_i with an acknowledge toggle plus a 7-bit SoC status field.
- Runs entirely in the SoC clock domain; the incoming byte is asynchronous (tck domain) and is synchronised and debounced here.

Parameters:
FIFO_DEPTH, 4, RX FIFO entries; power of two, >= 2
STABLE_CYCLES, 2, consecutive synchronised cycles a new input value must hold before it is accepted; >= 1

Ports:
clk_i  in  1  SoC clock
rst_ni  in  1  asynchronous active-low reset
jtag_reg_i  in  8  byte from JTAG confreg, async; [7] = host toggle, [6:0] = payload
jtag_reg_o  out  8  byte to JTAG side; [7] = ack toggle, [6:0] = status
status_i  in  7  SoC status value
status_we_i  in  1  load status_i into the status register
rx_data_o  out  7  FIFO head payload
rx_valid_o  out  1  FIFO not empty
rx_ready_i  in  1  consumer accepts head
rx_count_o  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy

Behaviour:
- Reset values:
  - sync FFs s1, s2 = 0; last-seen value = 0
  - accepted value r_host = 0; r_ack = 0; r_status = 0
  - FIFO empty; FSM = INIT
  - jtag_reg_o = 0x00, rx_valid_o = 0, rx_count_o = 0
- Synchroniser: 2-FF chain on all 8 bits (s1 -> s2). Only s2 is used downstream.
- Stability filter:
  - Counter restarts whenever s2 differs from its previous-cycle value.
  - A value is "settled" once s2 has been unchanged for STABLE_CYCLES consecutive cycles.
  - This prevents a multi-bit skewed capture from being accepted.
- FSM states and transitions:
  - INIT: wait for the first settled value; latch it into r_host; r_ack := r_host[7]; no push. -> IDLE.
    - Rationale: a SoC-only reset must not replay a stale byte still held by the JTAG side.
  - IDLE: if s2 != r_host, -> SETTLE.
  - SETTLE:
    - On settle, latch r_host := s2.
    - If r_host[7] == r_ack (same toggle, only payload changed): payload is ignored, no push, -> IDLE.
    - Else if FIFO not full: push payload, flip r_ack in the same cycle, -> IDLE.
    - Else -> WAIT_SPACE.
    - If s2 changes again before settling: stay in SETTLE, counter restarts.
  - WAIT_SPACE:
    - When FIFO not full: push r_host[6:0], flip r_ack, -> IDLE.
    - If s2 changes (host rewrote): -> SETTLE. Newest value wins; the unpushed byte is discarded.
- Latency: an input change reaches the FIFO after 2 (sync) + STABLE_CYCLES + 1 cycles, assuming space is available.
- jtag_reg_o:
  - Registered {r_ack, r_status}; r_ack updates the cycle after the push cycle.
  - r_status loads status_i the cycle after status_we_i = 1.
  - Host protocol:
    - Write a byte with an inverted toggle.
    - Poll until bit 7 equals the new toggle, then send the next byte.
    - Read status twice and require agreement, since status bits are not coherent across domains.
- FIFO behaviour:
  - First-word-fall-through; rx_data_o is valid whenever rx_valid_o = 1.
  - Pop occurs when rx_valid_o && rx_ready_i.
  - Push is blocked when full, even if a pop happens in the same cycle; the push completes the next cycle.
  - Simultaneous push and pop when not full: count unchanged, data order preserved.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - rx_count_o is exact (0..FIFO_DEPTH).
  - rx_data_o is don't-care when empty.
- Reset mid-operation: asserting rst_ni at any time returns the block to INIT with the FIFO cleared; bytes in flight are lost.
- No overflow error exists: flow control is carried by the ack toggle alone.

Test Plan:
- Reset with jtag_reg_i = 0x80 held -> after settle, jtag_reg_o = 0x80, rx_count_o = 0, no push (INIT baseline).
- From baseline 0x00, drive 0x85 -> after 2 + STABLE_CYCLES + 1 cycles rx_valid_o = 1, rx_data_o = 0x05, jtag_reg_o[7] = 1 one cycle later; pop -> rx_count_o = 0.
- Hold rx_ready_i = 0 and send five alternating-toggle bytes 0x81, 0x02, 0x83, 0x04, 0x85, each after observing the ack:
  - Expected: count reaches 4 and the fifth byte stalls in WAIT_SPACE with ack unchanged.
  - Then assert rx_ready_i for one cycle -> fifth byte is pushed one cycle later and ack flips; data order out is 0x01..0x05.
- Glitch test: drive 0x00 -> 0x8F for 1 cycle -> back to 0x00 (shorter than STABLE_CYCLES) -> no push, ack unchanged; change payload only (0x00 -> 0x12) -> no push.
- Status: status_we_i = 1 with status_i = 0x5A -> jtag_reg_o[6:0] = 0x5A next cycle, ack bit unaffected.
- Assert rst_ni low while in WAIT_SPACE with the FIFO full -> all outputs return to reset values immediately; after release, re-enter INIT and adopt the current input without pushing.

Source files
------------

// File: rtl/jtag_soc_mailbox.sv
// jtag_soc_mailbox: SoC-side consumer of the JTAG config byte.
// Sync + debounce, toggle handshake, FWFT RX FIFO, status return.
module jtag_soc_mailbox #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] jtag_reg_i,
  output logic [7:0] jtag_reg_o,
  input  logic [6:0] status_i,
  input  logic       status_we_i,
  output logic [6:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned NW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CW =
    (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  localparam logic [CW-1:0] CMAX  = CW'(STABLE_CYCLES - 1);
  localparam logic [NW-1:0] NFULL = NW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    SETTLE,
    WAIT_SPACE
  } state_e;

  state_e state;

  logic [7:0]    s1;
  logic [7:0]    s2;
  logic [7:0]    prev;
  logic [1:0]    sync_vld;
  logic [CW-1:0] cnt;
  logic          settled;

  logic [7:0]    r_host;
  logic          r_ack;
  logic          ack_q;
  logic [6:0]    r_status;

  logic [6:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [NW-1:0] count;
  logic          full;
  logic          push;
  logic          pop;
  logic [6:0]    push_data;

  // two-flop synchroniser plus previous-cycle copy of s2
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1       <= '0;
      s2       <= '0;
      prev     <= '0;
      sync_vld <= '0;
    end else begin
      s1       <= jtag_reg_i;
      s2       <= s1;
      prev     <= s2;
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  // stability counter; held at zero until the chain holds real data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (!sync_vld[1] || (s2 != prev)) begin
      cnt <= '0;
    end else if (cnt != CMAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign settled = sync_vld[1] && (s2 == prev) && (cnt == CMAX);

  assign full = (count == NFULL);
  assign pop  = rx_valid_o && rx_ready_i;

  // push decision for the current FSM state
  always_comb begin
    push      = 1'b0;
    push_data = r_host[6:0];
    unique case (state)
      SETTLE: begin
        if (settled && (s2[7] != r_ack) && !full) begin
          push      = 1'b1;
          push_data = s2[6:0];
        end
      end
      WAIT_SPACE: begin
        if (!full) push = 1'b1;
      end
      default: ;
    endcase
  end

  // handshake FSM: adopt, debounce, push and ack host bytes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= INIT;
      r_host <= '0;
      r_ack  <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          if (settled) begin
            r_host <= s2;
            r_ack  <= s2[7];
            state  <= IDLE;
          end
        end
        IDLE: begin
          if (s2 != r_host) state <= SETTLE;
        end
        SETTLE: begin
          if (settled) begin
            r_host <= s2;
            if (s2[7] == r_ack) begin
              state <= IDLE;
            end else if (!full) begin
              r_ack <= ~r_ack;
              state <= IDLE;
            end else begin
              state <= WAIT_SPACE;
            end
          end
        end
        WAIT_SPACE: begin
          if (!full) begin
            r_ack <= ~r_ack;
            state <= IDLE;
          end else if (s2 != r_host) begin
            state <= SETTLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // return byte to the TAP: delayed ack plus status register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q    <= 1'b0;
      r_status <= '0;
    end else begin
      ack_q <= r_ack;
      if (status_we_i) r_status <= status_i;
    end
  end

  assign jtag_reg_o = {ack_q, r_status};

  // FIFO storage, no reset needed
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers and exact occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rx_valid_o = (count != '0);
  assign rx_data_o  = mem[rd_ptr];
  assign rx_count_o = count;

endmodule

// File: tb/tb_jtag_soc_mailbox.sv
// tb_jtag_soc_mailbox: directed bench for the JTAG mailbox.
// Linear steps, immediate assertions, hand-computed values.
module tb_jtag_soc_mailbox;

  logic       clk;
  logic       rst_n;
  logic [7:0] jin;
  logic [7:0] jout;
  logic [6:0] st;
  logic       st_we;
  logic [6:0] rdat;
  logic       rvld;
  logic       rrdy;
  logic [2:0] rcnt;

  int total;
  int bad;

  jtag_soc_mailbox #(
    .FIFO_DEPTH(4),
    .STABLE_CYCLES(2)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .jtag_reg_i(jin),
    .jtag_reg_o(jout),
    .status_i(st),
    .status_we_i(st_we),
    .rx_data_o(rdat),
    .rx_valid_o(rvld),
    .rx_ready_i(rrdy),
    .rx_count_o(rcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input string tag,
                      input logic [7:0] b);
    logic ok;
    ok  = 1'b0;
    jin = b;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick(1);
      if (jout[7] === b[7]) ok = 1'b1;
    end
    chk(tag, 32'(ok), 1);
  endtask

  task automatic do_reset(input logic [7:0] b);
    rst_n = 1'b0;
    jin   = b;
    tick(2);
    rst_n = 1'b1;
    tick(12);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    jin   = 8'h80;
    st    = '0;
    st_we = 1'b0;
    rrdy  = 1'b0;
    tick(2);
    chk("rst_jout", 32'(jout), 'h00);
    chk("rst_vld",  32'(rvld), 0);
    chk("rst_cnt",  32'(rcnt), 0);

    // INIT adopts 0x80 without pushing
    rst_n = 1'b1;
    tick(12);
    chk("init80_jout", 32'(jout), 'h80);
    chk("init80_cnt",  32'(rcnt), 0);
    chk("init80_vld",  32'(rvld), 0);

    // baseline 0x00
    do_reset(8'h00);
    chk("base0_jout", 32'(jout), 'h00);
    chk("base0_cnt",  32'(rcnt), 0);

    // one-cycle glitch must not push
    jin = 8'h8F;
    tick(1);
    jin = 8'h00;
    tick(12);
    chk("glitch_cnt",  32'(rcnt), 0);
    chk("glitch_jout", 32'(jout), 'h00);

    // payload-only change is ignored
    jin = 8'h12;
    tick(12);
    chk("pay_cnt",  32'(rcnt), 0);
    chk("pay_jout", 32'(jout), 'h00);

    // latency: 2 + 2 + 1 cycles to FIFO
    jin = 8'h85;
    tick(4);
    chk("lat_vld4", 32'(rvld), 0);
    tick(1);
    chk("lat_vld5",  32'(rvld), 1);
    chk("lat_dat5",  32'(rdat), 'h05);
    chk("lat_cnt5",  32'(rcnt), 1);
    chk("lat_ack5",  32'(jout[7]), 0);
    tick(1);
    chk("lat_jout6", 32'(jout), 'h80);
    rrdy = 1'b1;
    tick(1);
    rrdy = 1'b0;
    chk("lat_pop_cnt", 32'(rcnt), 0);

    // fill FIFO from a fresh baseline
    do_reset(8'h00);
    send("ack_81", 8'h81);
    send("ack_02", 8'h02);
    send("ack_83", 8'h83);
    send("ack_04", 8'h04);
    chk("fill_cnt", 32'(rcnt), 4);
    jin = 8'h85;
    tick(12);
    chk("stall_cnt", 32'(rcnt), 4);
    chk("stall_ack", 32'(jout[7]), 0);
    chk("stall_head", 32'(rdat), 'h01);

    // status load, ack bit untouched
    st    = 7'h5A;
    st_we = 1'b1;
    tick(1);
    st_we = 1'b0;
    st    = 7'h00;
    chk("status_jout", 32'(jout), 'h5A);

    // one-cycle pop releases the stalled byte
    rrdy = 1'b1;
    tick(1);
    rrdy = 1'b0;
    chk("rel_cnt_a",  32'(rcnt), 3);
    chk("rel_head",   32'(rdat), 'h02);
    tick(1);
    chk("rel_cnt_b",  32'(rcnt), 4);
    chk("rel_jout_b", 32'(jout), 'h5A);
    tick(1);
    chk("rel_jout_c", 32'(jout), 'hDA);

    // drain and check order
    for (int i = 2; i <= 5; i++) begin
      chk($sformatf("drain_%0d", i), 32'(rdat), i);
      rrdy = 1'b1;
      tick(1);
      rrdy = 1'b0;
    end
    chk("drain_cnt", 32'(rcnt), 0);
    chk("drain_vld", 32'(rvld), 0);

    // refill until the fifth byte stalls
    send("ack_06", 8'h06);
    send("ack_87", 8'h87);
    send("ack_08", 8'h08);
    send("ack_89", 8'h89);
    jin = 8'h0A;
    tick(12);
    chk("stall2_cnt",  32'(rcnt), 4);
    chk("stall2_jout", 32'(jout), 'hDA);

    // asynchronous reset in WAIT_SPACE
    rst_n = 1'b0;
    #1;
    chk("arst_jout", 32'(jout), 'h00);
    chk("arst_vld",  32'(rvld), 0);
    chk("arst_cnt",  32'(rcnt), 0);
    tick(2);
    rst_n = 1'b1;
    tick(12);
    chk("reinit_cnt",  32'(rcnt), 0);
    chk("reinit_jout", 32'(jout), 'h00);

    // adopted 0x0A, so the next toggle pushes
    send("ack_8B", 8'h8B);
    chk("post_cnt",  32'(rcnt), 1);
    chk("post_dat",  32'(rdat), 'h0B);
    chk("post_jout", 32'(jout), 'h80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
